// File: rtl/data_memory_ctrl.sv
// Byte-addressed little-endian data memory with sized accesses,
// fault detection, programmable wait states and valid/ready handshake.
module data_memory_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  input  logic        i_rsp_ready
);

  localparam int          DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  WC    = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        cnt_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [7:0] mem [DEPTH];

  logic              req_err;
  logic              accept;
  logic              access;
  logic              a_we;
  logic [1:0]        a_size;
  logic              a_signed;
  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [31:0]       raw;
  logic [31:0]       ld;
  logic [3:0]        be;

  // Classify an incoming request as faulting (size, alignment, range).
  always_comb begin
    req_err = 1'b0;
    case (i_req_size)
      2'b00:   req_err = 1'b0;
      2'b01:   req_err = i_req_addr[0];
      2'b10:   req_err = |i_req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (i_req_addr[31:ADDR_W] != '0)
      req_err = 1'b1;
  end

  assign accept = (state_q == S_IDLE) && i_req_valid;

  // Access happens on the accept edge when there are no wait states,
  // otherwise on the last WAIT edge using the latched request.
  always_comb begin
    access = 1'b0;
    if (accept && !req_err && (WC == 4'd0))
      access = 1'b1;
    else if ((state_q == S_WAIT) && (cnt_q == 4'd0))
      access = 1'b1;
  end

  // Select live inputs on the fast path, latched fields otherwise.
  always_comb begin
    a_we     = we_q;
    a_size   = size_q;
    a_signed = signed_q;
    a_addr   = addr_q;
    a_wdata  = wdata_q;
    if (state_q == S_IDLE) begin
      a_we     = i_req_we;
      a_size   = i_req_size;
      a_signed = i_req_signed;
      a_addr   = i_req_addr[ADDR_W-1:0];
      a_wdata  = i_req_wdata;
    end
  end

  // Gather four consecutive bytes and extend to the access size.
  always_comb begin
    raw = '0;
    for (int k = 0; k < 4; k++)
      raw[8*k +: 8] = mem[a_addr + ADDR_W'(k)];
    ld = raw;
    be = 4'b1111;
    case (a_size)
      2'b00: begin
        ld = {{24{a_signed & raw[7]}}, raw[7:0]};
        be = 4'b0001;
      end
      2'b01: begin
        ld = {{16{a_signed & raw[15]}}, raw[15:0]};
        be = 4'b0011;
      end
      default: begin
        ld = raw;
        be = 4'b1111;
      end
    endcase
  end

  // Byte-enabled store into the array; never written during reset.
  always_ff @(posedge clk) begin
    if (rstn && access && a_we) begin
      for (int k = 0; k < 4; k++)
        if (be[k])
          mem[a_addr + ADDR_W'(k)] <= a_wdata[8*k +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid)
          state_d = (req_err || (WC == 4'd0)) ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0)
          state_d = S_RESP;
      end
      S_RESP: begin
        o_rsp_valid = 1'b1;
        if (i_rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q    <= WC - 4'd1;
        we_q     <= i_req_we;
        size_q   <= i_req_size;
        signed_q <= i_req_signed;
        addr_q   <= i_req_addr[ADDR_W-1:0];
        wdata_q  <= i_req_wdata;
        err_q    <= req_err;
        rdata_q  <= '0;
      end else if ((state_q == S_WAIT) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (access)
        rdata_q <= a_we ? 32'd0 : ld;
    end
  end

  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (2 and 0 wait states)
// driven in lockstep and checked against a byte-array model.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid, we, sgn, rsp_ready;
  logic [1:0]  size;
  logic [31:0] addr, wdata;

  logic [1:0]        rdy, vld, er;
  logic [1:0][31:0]  rd;

  int tests = 0;
  int fails = 0;

  logic [7:0] mdl [2][1024];

  always #5 clk = ~clk;

  data_memory_ctrl #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rstn(rstn),
    .i_req_valid(valid), .o_req_ready(rdy[0]),
    .i_req_we(we), .i_req_size(size), .i_req_signed(sgn),
    .i_req_addr(addr), .i_req_wdata(wdata),
    .o_rsp_valid(vld[0]), .o_rsp_rdata(rd[0]), .o_rsp_err(er[0]),
    .i_rsp_ready(rsp_ready)
  );

  data_memory_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rstn(rstn),
    .i_req_valid(valid), .o_req_ready(rdy[1]),
    .i_req_we(we), .i_req_size(size), .i_req_signed(sgn),
    .i_req_addr(addr), .i_req_wdata(wdata),
    .o_rsp_valid(vld[1]), .o_rsp_rdata(rd[1]), .o_rsp_err(er[1]),
    .i_rsp_ready(rsp_ready)
  );

  function automatic int wc(int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model(int i, logic mwe, logic [1:0] msz, logic msg,
                       logic [31:0] ma, logic [31:0] mwd,
                       output logic merr, output logic [31:0] mrd);
    int n;
    n = 1 << msz;
    merr = (msz == 2'd3) || (ma >= 32'd1024) || ((ma % n) != 0);
    mrd = '0;
    if (merr) return;
    if (mwe) begin
      for (int k = 0; k < n; k++)
        mdl[i][int'(ma) + k] = mwd[8*k +: 8];
    end else begin
      for (int k = 0; k < n; k++)
        mrd = mrd | (32'(mdl[i][int'(ma) + k]) << (8 * k));
      if (msg && n < 4 && mrd[8*n-1])
        mrd = mrd | (32'hFFFF_FFFF << (8 * n));
    end
  endtask

  task automatic xact(logic twe, logic [1:0] tsz, logic tsg,
                      logic [31:0] ta, logic [31:0] twd, int hold);
    logic        e [2];
    logic [31:0] r [2];
    int          lat [2];
    for (int i = 0; i < 2; i++)
      chk($sformatf("ready_idle%0d", i), 32'(rdy[i]), 32'd1);
    valid = 1'b1;
    we    = twe;
    size  = tsz;
    sgn   = tsg;
    addr  = ta;
    wdata = twd;
    for (int i = 0; i < 2; i++)
      model(i, twe, tsz, tsg, ta, twd, e[i], r[i]);
    @(posedge clk); #1;
    valid = 1'b0;
    we    = 1'($urandom);
    size  = 2'($urandom);
    sgn   = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    lat[0] = -1;
    lat[1] = -1;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < 2; i++)
        if (lat[i] < 0 && vld[i]) lat[i] = c;
      if (lat[0] >= 0 && lat[1] >= 0) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("latency%0d", i), 32'(lat[i]),
          32'(e[i] ? 0 : wc(i)));
      chk($sformatf("rdata%0d", i), rd[i], r[i]);
      chk($sformatf("err%0d", i), 32'(er[i]), 32'(e[i]));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("hold_valid%0d", i), 32'(vld[i]), 32'd1);
        chk($sformatf("hold_ready%0d", i), 32'(rdy[i]), 32'd0);
        chk($sformatf("hold_rdata%0d", i), rd[i], r[i]);
        chk($sformatf("hold_err%0d", i), 32'(er[i]), 32'(e[i]));
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++)
      chk($sformatf("valid_drop%0d", i), 32'(vld[i]), 32'd0);
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rs;
    logic        de;
    logic [31:0] dr;

    valid = 0; we = 0; sgn = 0; rsp_ready = 0;
    size = 0; addr = 0; wdata = 0;

    #12;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("rst_valid%0d", i), 32'(vld[i]), 32'd0);
      chk($sformatf("rst_rdata%0d", i), rd[i], 32'd0);
      chk($sformatf("rst_err%0d", i), 32'(er[i]), 32'd0);
    end
    rstn = 1'b1;
    @(posedge clk); #1;

    for (int a = 0; a < 128; a += 4)
      xact(1, 2'd2, 0, 32'(a), $urandom, 0);

    xact(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 0);
    xact(0, 2'd2, 0, 32'h10, 32'h0, 0);
    xact(1, 2'd0, 0, 32'h11, 32'h0000_0055, 0);
    xact(0, 2'd2, 0, 32'h10, 32'h0, 0);
    xact(0, 2'd0, 1, 32'h13, 32'h0, 0);
    xact(0, 2'd0, 0, 32'h13, 32'h0, 0);
    xact(0, 2'd1, 1, 32'h12, 32'h0, 0);

    xact(0, 2'd2, 0, 32'h12, 32'h0, 0);
    xact(1, 2'd1, 0, 32'h21, 32'hFFFF_FFFF, 0);
    xact(1, 2'd3, 0, 32'h10, 32'h1111_1111, 0);
    xact(0, 2'd2, 0, 32'h400, 32'h0, 0);
    xact(1, 2'd2, 0, 32'h410, 32'h2222_2222, 0);
    xact(0, 2'd2, 0, 32'h10, 32'h0, 0);
    xact(0, 2'd2, 0, 32'h20, 32'h0, 0);

    xact(0, 2'd2, 0, 32'h10, 32'h0, 5);
    xact(0, 2'd1, 0, 32'h12, 32'h0, 0);

    for (int t = 0; t < 60; t++) begin
      rs = ($urandom % 8 == 0) ? 2'd3 : 2'($urandom % 3);
      ra = 32'($urandom_range(0, 127));
      if ((rs != 2'd3) && ($urandom % 4 != 0))
        ra = ra & ~((32'd1 << rs) - 32'd1);
      if ($urandom % 10 == 0)
        ra = ra | (32'h400 << ($urandom % 22));
      xact(1'($urandom), rs, 1'($urandom), ra, $urandom,
           int'($urandom % 3));
    end

    xact(1, 2'd2, 0, 32'h20, 32'hAAAA_AAAA, 0);
    valid = 1'b1;
    we    = 1'b1;
    size  = 2'd2;
    sgn   = 1'b0;
    addr  = 32'h20;
    wdata = 32'h1234_5678;
    model(1, 1, 2'd2, 0, 32'h20, 32'h1234_5678, de, dr);
    @(posedge clk); #1;
    valid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("abort_ready%0d", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("abort_valid%0d", i), 32'(vld[i]), 32'd0);
      chk($sformatf("abort_rdata%0d", i), rd[i], 32'd0);
      chk($sformatf("abort_err%0d", i), 32'(er[i]), 32'd0);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    xact(0, 2'd2, 0, 32'h20, 32'h0, 0);
    xact(0, 2'd1, 1, 32'h22, 32'h0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
